// File: rtl/status_pager.sv
// status_pager: formats N_CH labelled BCD counters into CHARS-wide pages and
// streams them one ASCII character per valid/ready handshake to an LCD driver.
// Counts and labels are snapshotted once per frame so every page is coherent.
module status_pager #(
   parameter int unsigned N_CH      = 6,
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned CHARS     = 32,
   parameter int unsigned PAGE_HOLD = 50000000,
   parameter int unsigned LZB       = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_CH*DIGITS*4-1:0]         counts,
   input  logic [N_CH*16-1:0]               labels,
   input  logic                             hold_page,
   input  logic                             refresh,
   output logic [7:0]                       char_data,
   output logic [$clog2(CHARS)-1:0]         char_addr,
   output logic                             char_valid,
   input  logic                             char_ready,
   output logic                             frame_done,
   output logic [$clog2((N_CH + CHARS/(DIGITS+4) - 1)/(CHARS/(DIGITS+4))):0] page
);

   localparam int unsigned FW     = DIGITS + 4;
   localparam int unsigned SLOTS  = CHARS / FW;
   localparam int unsigned NPAGES = (N_CH + SLOTS - 1) / SLOTS;
   localparam int unsigned AW     = $clog2(CHARS);
   localparam int unsigned PW     = $clog2(NPAGES) + 1;
   localparam int unsigned HW     = $clog2(PAGE_HOLD) + 1;

   typedef enum logic [1:0] {SNAP, LOAD, SEND, HOLD} state_t;

   state_t                    state;
   logic [N_CH*DIGITS*4-1:0]  snap_counts;
   logic [N_CH*16-1:0]        snap_labels;
   logic [HW-1:0]             hold_cnt;
   logic                      refresh_latch;

   logic [AW-1:0]             lk_addr;
   logic [31:0]               lk_slot;
   logic [31:0]               lk_pos;
   logic [31:0]               lk_ch;
   logic [31:0]               lk_base;
   logic [31:0]               lk_dig;
   logic                      lk_used;
   logic                      lk_lz;
   logic [3:0]                lk_nib;
   logic [7:0]                lk_char;

   // Character generator: the glyph at lk_addr of the current page, taken from the snapshot
   always_comb begin
      lk_addr = (state == SEND) ? char_addr + AW'(1) : '0;
      lk_slot = 32'(lk_addr) / FW;
      lk_pos  = 32'(lk_addr) % FW;
      lk_ch   = 32'(page) * SLOTS + lk_slot;
      lk_used = (lk_slot < SLOTS) && (lk_ch < N_CH);
      lk_base = lk_used ? lk_ch : '0;
      lk_dig  = lk_pos - 32'd3;
      lk_lz   = 1'b1;
      lk_nib  = '0;
      lk_char = 8'h20;
      if (lk_used) begin
         if (lk_pos == 32'd0) begin
            lk_char = snap_labels[lk_base*16 +: 8];
         end else if (lk_pos == 32'd1) begin
            lk_char = snap_labels[lk_base*16 + 8 +: 8];
         end else if (lk_pos == 32'd2) begin
            lk_char = 8'h3A;
         end else if (lk_pos < DIGITS + 3) begin
            // lk_lz tracks "every digit up to and including this one is zero"
            for (int unsigned d = 0; d < DIGITS; d++) begin
               lk_nib = snap_counts[lk_base*DIGITS*4 + (DIGITS-1-d)*4 +: 4];
               if (lk_nib != 4'h0) lk_lz = 1'b0;
               if (d == lk_dig) begin
                  if (LZB != 0 && lk_lz && d != DIGITS - 1) lk_char = 8'h20;
                  else if (lk_nib > 4'h9)                   lk_char = 8'h3F;
                  else                                      lk_char = {4'h3, lk_nib};
               end
            end
         end
      end
   end

   // Frame sequencer: snapshot, stream CHARS characters, hold, rotate page
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= SNAP;
         char_valid    <= 1'b0;
         char_data     <= 8'h20;
         char_addr     <= '0;
         frame_done    <= 1'b0;
         page          <= '0;
         hold_cnt      <= '0;
         refresh_latch <= 1'b0;
         snap_counts   <= '0;
         snap_labels   <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            SNAP: begin
               snap_counts <= counts;
               snap_labels <= labels;
               state       <= LOAD;
            end
            LOAD: begin
               char_addr  <= '0;
               char_data  <= lk_char;
               char_valid <= 1'b1;
               state      <= SEND;
            end
            SEND: begin
               if (char_ready) begin
                  if (char_addr == AW'(CHARS - 1)) begin
                     char_valid <= 1'b0;
                     frame_done <= 1'b1;
                     hold_cnt   <= '0;
                     state      <= HOLD;
                  end else begin
                     char_addr <= char_addr + AW'(1);
                     char_data <= lk_char;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == HW'(PAGE_HOLD - 1) || refresh || refresh_latch) begin
                  refresh_latch <= 1'b0;
                  if (!hold_page) begin
                     page <= (page == PW'(NPAGES - 1)) ? '0 : page + PW'(1);
                  end
                  state <= SNAP;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: state <= SNAP;
         endcase
         // A refresh seen outside HOLD is remembered until the next HOLD consumes it
         if (refresh && state != HOLD) refresh_latch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_status_pager.sv
// tb_status_pager: directed tests for status_pager (LZB=0 and LZB=1 instances
// driven in lockstep from the same inputs, PAGE_HOLD shortened to 4).
module tb_status_pager;

   localparam int unsigned N_CH      = 6;
   localparam int unsigned DIGITS    = 4;
   localparam int unsigned CHARS     = 32;
   localparam int unsigned PAGE_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [95:0] counts;
   logic [95:0] labels;
   logic        hold_page;
   logic        refresh;
   logic        char_ready;
   logic [7:0]  char_data, char_data_l;
   logic [4:0]  char_addr, char_addr_l;
   logic        char_valid, char_valid_l;
   logic        frame_done, frame_done_l;
   logic [1:0]  page, page_l;

   int vectors = 0;
   int miscompares = 0;

   // capture results
   int          acc;
   int          stalls;
   int          gap;
   logic        order_ok, stable_ok, early_done, timeout, sync_ok, done1, done2;
   logic [1:0]  pg;
   logic [7:0]  b0 [32];
   logic [7:0]  b1 [32];
   string       got0, got1;

   string SP16, P0_0, P0_1, P1_0, P1_1, P1U;

   always #5 clk = ~clk;

   status_pager #(.N_CH(N_CH), .DIGITS(DIGITS), .CHARS(CHARS), .PAGE_HOLD(PAGE_HOLD), .LZB(0)) dut (
      .clk(clk), .rst(rst), .counts(counts), .labels(labels), .hold_page(hold_page),
      .refresh(refresh), .char_data(char_data), .char_addr(char_addr), .char_valid(char_valid),
      .char_ready(char_ready), .frame_done(frame_done), .page(page));

   status_pager #(.N_CH(N_CH), .DIGITS(DIGITS), .CHARS(CHARS), .PAGE_HOLD(PAGE_HOLD), .LZB(1)) dut_lzb (
      .clk(clk), .rst(rst), .counts(counts), .labels(labels), .hold_page(hold_page),
      .refresh(refresh), .char_data(char_data_l), .char_addr(char_addr_l), .char_valid(char_valid_l),
      .char_ready(char_ready), .frame_done(frame_done_l), .page(page_l));

   // Stream one full frame; ready is only asserted here, so the DUT waits at addr 0 otherwise
   task automatic capture(input int stall_at, input int stall_len, input int refresh_at, input int change_at);
      int cyc;
      int stall_left;
      logic [7:0] hd;
      logic [4:0] ha;
      logic have_h;
      acc = 0; stalls = 0; cyc = 0; stall_left = stall_len; have_h = 1'b0;
      order_ok = 1'b1; stable_ok = 1'b1; early_done = 1'b0; timeout = 1'b0; sync_ok = 1'b1;
      pg = 2'b11; hd = '0; ha = '0;
      while (acc < 32 && !timeout) begin
         @(negedge clk);
         cyc++;
         refresh = 1'b0;
         if (cyc > 300) timeout = 1'b1;
         if (frame_done) early_done = 1'b1;
         if (char_valid_l !== char_valid || char_addr_l !== char_addr ||
             page_l !== page || frame_done_l !== frame_done) sync_ok = 1'b0;
         if (char_valid === 1'b1) begin
            if (int'(char_addr) == stall_at && stall_left > 0) begin
               char_ready = 1'b0;
               stall_left--;
               stalls++;
               if (!have_h) begin
                  hd = char_data; ha = char_addr; have_h = 1'b1;
               end else if (char_data !== hd || char_addr !== ha) begin
                  stable_ok = 1'b0;
               end
            end else begin
               char_ready = 1'b1;
               if (have_h && int'(char_addr) == stall_at && char_data !== hd) stable_ok = 1'b0;
               if (acc == 0) pg = page;
               if (int'(char_addr) != acc) order_ok = 1'b0;
               b0[acc] = char_data;
               b1[acc] = char_data_l;
               acc++;
               if (acc - 1 == refresh_at) refresh = 1'b1;
               if (acc - 1 == change_at) counts[64 +: 16] = 16'h4567;
            end
         end else begin
            char_ready = 1'b0;
         end
      end
      @(negedge clk);
      refresh = 1'b0;
      char_ready = 1'b0;
      done1 = frame_done;
      @(negedge clk);
      done2 = frame_done;
      got0 = ""; got1 = "";
      for (int i = 0; i < acc; i++) begin
         got0 = {got0, $sformatf("%c", b0[i])};
         got1 = {got1, $sformatf("%c", b1[i])};
      end
   endtask

   // Cycles from the return of capture until the next frame's first char is valid
   task automatic measure_gap();
      gap = 0;
      while (char_valid !== 1'b1 && gap < 50) begin
         @(negedge clk);
         gap++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", char_valid); end
      vectors++; if (char_data !== 8'h20) begin miscompares++; $display("FAIL rst_data got %h want 20", char_data); end
      vectors++; if (char_addr !== 5'd0) begin miscompares++; $display("FAIL rst_addr got %0d want 0", char_addr); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", frame_done); end
      vectors++; if (page !== 2'd0) begin miscompares++; $display("FAIL rst_page got %0d want 0", page); end
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("FAIL rel_edge1_valid got %b want 0", char_valid); end
      @(negedge clk);
      vectors++; if (char_valid !== 1'b1) begin miscompares++; $display("FAIL rel_edge2_valid got %b want 1", char_valid); end
      vectors++; if (char_data !== 8'h4E) begin miscompares++; $display("FAIL rel_first_char got %h want 4e", char_data); end
   endtask

   task automatic test_format();
      capture(-1, 0, -1, -1);
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL fmt_timeout got %0d accepts want 32", acc); end
      vectors++; if (acc != 32) begin miscompares++; $display("FAIL fmt_accepts got %0d want 32", acc); end
      vectors++; if (order_ok !== 1'b1) begin miscompares++; $display("FAIL fmt_addr_order got %b want 1", order_ok); end
      vectors++; if (pg !== 2'd0) begin miscompares++; $display("FAIL fmt_page got %0d want 0", pg); end
      vectors++; if (got0 != P0_0) begin miscompares++; $display("FAIL fmt_page0 got \"%s\" want \"%s\"", got0, P0_0); end
      vectors++; if (got1 != P0_1) begin miscompares++; $display("FAIL lzb_page0 got \"%s\" want \"%s\"", got1, P0_1); end
      vectors++; if (early_done !== 1'b0) begin miscompares++; $display("FAIL fmt_early_done got %b want 0", early_done); end
      vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL fmt_done_pulse got %b want 1", done1); end
      vectors++; if (done2 !== 1'b0) begin miscompares++; $display("FAIL fmt_done_width got %b want 0", done2); end
      vectors++; if (sync_ok !== 1'b1) begin miscompares++; $display("FAIL lzb_lockstep got %b want 1", sync_ok); end
   endtask

   task automatic test_paging();
      measure_gap();
      vectors++; if (gap != 5) begin miscompares++; $display("FAIL hold_gap got %0d want 5", gap); end
      capture(-1, 0, -1, -1);
      vectors++; if (pg !== 2'd1) begin miscompares++; $display("FAIL page_adv got %0d want 1", pg); end
      vectors++; if (got0 != P1_0) begin miscompares++; $display("FAIL page1 got \"%s\" want \"%s\"", got0, P1_0); end
      vectors++; if (got1 != P1_1) begin miscompares++; $display("FAIL lzb_page1 got \"%s\" want \"%s\"", got1, P1_1); end
      capture(-1, 0, -1, -1);
      vectors++; if (pg !== 2'd0) begin miscompares++; $display("FAIL page_wrap got %0d want 0", pg); end
      vectors++; if (got0 != P0_0) begin miscompares++; $display("FAIL wrap_page0 got \"%s\" want \"%s\"", got0, P0_0); end
   endtask

   task automatic test_backpressure();
      capture(9, 5, -1, -1);
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL bp_timeout got %0d accepts want 32", acc); end
      vectors++; if (stalls != 5) begin miscompares++; $display("FAIL bp_stalls got %0d want 5", stalls); end
      vectors++; if (stable_ok !== 1'b1) begin miscompares++; $display("FAIL bp_held_stable got %b want 1", stable_ok); end
      vectors++; if (acc != 32) begin miscompares++; $display("FAIL bp_accepts got %0d want 32", acc); end
      vectors++; if (order_ok !== 1'b1) begin miscompares++; $display("FAIL bp_addr_order got %b want 1", order_ok); end
      vectors++; if (got0 != P1_0) begin miscompares++; $display("FAIL bp_page1 got \"%s\" want \"%s\"", got0, P1_0); end
      vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL bp_done_pulse got %b want 1", done1); end
   endtask

   task automatic test_control();
      hold_page = 1'b1;
      measure_gap();
      capture(-1, 0, -1, -1);
      vectors++; if (pg !== 2'd1) begin miscompares++; $display("FAIL holdpg_a got %0d want 1", pg); end
      measure_gap();
      vectors++; if (gap != 5) begin miscompares++; $display("FAIL holdpg_gap got %0d want 5", gap); end
      capture(-1, 0, 5, -1);
      vectors++; if (pg !== 2'd1) begin miscompares++; $display("FAIL holdpg_b got %0d want 1", pg); end
      measure_gap();
      vectors++; if (gap != 2) begin miscompares++; $display("FAIL refresh_gap got %0d want 2", gap); end
      capture(-1, 0, -1, 10);
      vectors++; if (pg !== 2'd1) begin miscompares++; $display("FAIL holdpg_c got %0d want 1", pg); end
      vectors++; if (got0 != P1_0) begin miscompares++; $display("FAIL snap_coherent got \"%s\" want \"%s\"", got0, P1_0); end
      measure_gap();
      capture(-1, 0, -1, -1);
      vectors++; if (pg !== 2'd1) begin miscompares++; $display("FAIL holdpg_d got %0d want 1", pg); end
      vectors++; if (got0 != P1U) begin miscompares++; $display("FAIL snap_update got \"%s\" want \"%s\"", got0, P1U); end
      vectors++; if (got1 != P1U) begin miscompares++; $display("FAIL lzb_update got \"%s\" want \"%s\"", got1, P1U); end
   endtask

   task automatic test_reset_mid();
      measure_gap();
      repeat (5) begin
         @(negedge clk);
         char_ready = 1'b1;
      end
      @(negedge clk);
      char_ready = 1'b0;
      vectors++; if (char_addr !== 5'd5) begin miscompares++; $display("FAIL mid_addr got %0d want 5", char_addr); end
      vectors++; if (page !== 2'd1) begin miscompares++; $display("FAIL mid_page_pre got %0d want 1", page); end
      rst = 1'b1;
      #1;
      vectors++; if (char_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid got %b want 0", char_valid); end
      vectors++; if (char_data !== 8'h20) begin miscompares++; $display("FAIL mid_rst_data got %h want 20", char_data); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done got %b want 0", frame_done); end
      vectors++; if (page !== 2'd0) begin miscompares++; $display("FAIL mid_rst_page got %0d want 0", page); end
      vectors++; if (char_addr !== 5'd0) begin miscompares++; $display("FAIL mid_rst_addr got %0d want 0", char_addr); end
      hold_page = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (char_valid !== 1'b0 || frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_rel_edge1 got valid=%b done=%b want 0 0", char_valid, frame_done); end
      @(negedge clk);
      vectors++; if (char_valid !== 1'b1 || char_addr !== 5'd0) begin miscompares++; $display("FAIL mid_rel_edge2 got valid=%b addr=%0d want 1 0", char_valid, char_addr); end
      capture(-1, 0, -1, -1);
      vectors++; if (pg !== 2'd0) begin miscompares++; $display("FAIL mid_restart_page got %0d want 0", pg); end
      vectors++; if (got0 != P0_0) begin miscompares++; $display("FAIL mid_restart_frame got \"%s\" want \"%s\"", got0, P0_0); end
      vectors++; if (got1 != P0_1) begin miscompares++; $display("FAIL mid_restart_lzb got \"%s\" want \"%s\"", got1, P0_1); end
      vectors++; if (done1 !== 1'b1) begin miscompares++; $display("FAIL mid_restart_done got %b want 1", done1); end
   endtask

   // Stimulus sequence
   initial begin
      SP16 = {"        ", "        "};
      P0_0 = "NS:0123 AB:00?5 CD:0000 WE:9870 ";
      P0_1 = "NS: 123 AB:  ?5 CD:   0 WE:9870 ";
      P1_0 = {"EF:0042 GH:1000 ", SP16};
      P1_1 = {"EF:  42 GH:1000 ", SP16};
      P1U  = {"EF:4567 GH:1000 ", SP16};
      labels     = {"HG", "FE", "EW", "DC", "BA", "SN"};
      counts     = {16'h1000, 16'h0042, 16'h9870, 16'h0000, 16'h00A5, 16'h0123};
      hold_page  = 1'b0;
      refresh    = 1'b0;
      char_ready = 1'b0;
      test_reset();
      test_format();
      test_paging();
      test_backpressure();
      test_control();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Run-time bound
   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule
